// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU (34-cycle latency).
// Optional macro DIV_EARLY_EXIT_EN: skip the iteration loop when b==0 or |b| > |a| (latency 2).
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] ITER = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [1:0]      state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [CW-1:0]   cnt;
  logic            qsign;
  logic            rsign;

  logic            is_signed;
  logic            sel_quo;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            b_zero;
  logic            early;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub;
  logic            ge;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Operand magnitudes, one restoring step and final sign correction.
  always_comb begin
    is_signed = (op_q == DIV_OP_DIV) || (op_q == DIV_OP_REM);
    sel_quo   = (op_q == DIV_OP_DIV) || (op_q == DIV_OP_DIVU);
    b_zero    = (b_q == {XLEN{1'b0}});
    if (is_signed && a_q[XLEN-1]) begin
      a_mag = neg(a_q);
    end else begin
      a_mag = a_q;
    end
    if (is_signed && b_q[XLEN-1]) begin
      b_mag = neg(b_q);
    end else begin
      b_mag = b_q;
    end
`ifdef DIV_EARLY_EXIT_EN
    early = b_zero || (b_mag > a_mag);
`else
    early = 1'b0;
`endif
    // Partial remainder never exceeds the divisor, so the low XLEN bits of the difference are exact.
    rem_sh  = {rem, quo[XLEN-1]};
    ge      = (rem_sh >= {1'b0, div_q});
    rem_sub = rem_sh[XLEN-1:0] - div_q;
    if (qsign) begin
      q_fin = neg(quo);
    end else begin
      q_fin = quo;
    end
    if (rsign) begin
      r_fin = neg(rem);
    end else begin
      r_fin = rem;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      a_q    <= {XLEN{1'b0}};
      b_q    <= {XLEN{1'b0}};
      div_q  <= {XLEN{1'b0}};
      quo    <= {XLEN{1'b0}};
      rem    <= {XLEN{1'b0}};
      cnt    <= {CW{1'b0}};
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= {XLEN{1'b0}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            busy  <= 1'b1;
            state <= PREP;
          end else begin
            state <= IDLE;
          end
        end
        PREP: begin
          div_q <= b_mag;
          cnt   <= LAST;
          // Divide-by-zero keeps the all-ones quotient unsigned.
          qsign <= is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]) && !b_zero;
          rsign <= is_signed && a_q[XLEN-1];
          if (early) begin
            quo   <= b_zero ? {XLEN{1'b1}} : {XLEN{1'b0}};
            rem   <= a_mag;
            state <= FIN;
          end else begin
            quo   <= a_mag;
            rem   <= {XLEN{1'b0}};
            state <= ITER;
          end
        end
        ITER: begin
          if (ge) begin
            rem <= rem_sub;
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          if (cnt == {CW{1'b0}}) begin
            state <= FIN;
          end else begin
            cnt   <= cnt - {{(CW-1){1'b0}}, 1'b1};
            state <= ITER;
          end
        end
        FIN: begin
          result <= sel_quo ? q_fin : r_fin;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking scoreboard bench for div_unit; honours DIV_EARLY_EXIT_EN for expected latency.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (o)
      2'b00: begin
        if (y == 32'd0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(x) / $signed(y);
      end
      2'b01: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      2'b10: begin
        if (y == 32'd0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(x) % $signed(y);
      end
      default: r = (y == 32'd0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int l;
    l = 34;
`ifdef DIV_EARLY_EXIT_EN
    if (y == 32'd0 || mag(!o[0], y) > mag(!o[0], x)) l = 2;
`endif
    return l;
  endfunction

  // Drives start for one edge (edge 0) and scrambles operands afterwards.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e.res = ref_res(o, x, y);
    e.lat = ref_lat(o, x, y);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string tag, input bit poke);
    int   cyc;
    exp_t e;
    cyc = 0;
    e = sb.pop_front();
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (done) break;
      if (poke && (cyc == 4 || cyc == 19)) begin
        start = 1'b1;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom_range(1, 9);
      end else if (poke && (cyc == 5 || cyc == 20)) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(cyc), 32'(e.lat));
    check({tag, "_res"}, result, e.res);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    issue(o, x, y);
    wait_done(tag, 1'b0);
  endtask

  initial begin
    int          extra;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rstn  = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    run("divu_100_7", 2'b01, 32'd100, 32'd7);
    run("remu_100_7", 2'b11, 32'd100, 32'd7);
    run("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7);
    run("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7);
    run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run("div_by0", 2'b00, 32'd5, 32'd0);
    run("divu_by0", 2'b01, 32'd5, 32'd0);
    run("rem_by0", 2'b10, 32'd5, 32'd0);
    run("rem_neg_by0", 2'b10, 32'hFFFF_FFF0, 32'd0);
    run("div_small_big", 2'b00, 32'd3, 32'hFFFF_FF00);

    // Starts during an operation are ignored; a start in the done cycle is taken.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7);
    wait_done("poke", 1'b1);
    issue(2'b10, 32'hFFFF_FF9C, 32'd7);
    wait_done("b2b", 1'b0);
    count_dones(40, extra);
    check("no_extra_done", 32'(extra), 32'd0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    issue(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    void'(sb.pop_front());
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    count_dones(40, extra);
    check("abort_no_done", 32'(extra), 32'd0);
    run("after_abort", 2'b01, 32'd1000, 32'd3);

    for (int i = 0; i < 8; i++) begin
      ro = 2'(i);
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i == 5) rb = 32'hFFFF_FFFD;
      run("rand", ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
